// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Five-button front end. Each raw button is synchronized and
//            debounced. The four direction buttons produce a press strobe
//            followed by auto-repeat strobes. The attack button produces one
//            strobe per press, rate-limited by a cooldown. A shared prescaler
//            provides the control-rate and game-rate enable strobes.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DB_CYCLES     = 1000000,
    parameter int REP_DELAY     = 50000000,
    parameter int REP_PERIOD    = 20000000,
    parameter int FIRE_COOLDOWN = 150000000,
    parameter int CTRL_DIV      = 10000000,
    parameter int GAME_DIV      = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_in,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse,
    output logic       ctrl_tick,
    output logic       game_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_NUM_DIR = 4;
    localparam int c_ATT_BIT = 4;

    localparam int c_DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_TMR_MX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int c_TMR_W  = (c_TMR_MX > 1) ? $clog2(c_TMR_MX) : 1;
    localparam int c_CD_W   = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam int c_PRE_W  = (CTRL_DIV > 1) ? $clog2(CTRL_DIV) : 1;
    localparam int c_GAME_W = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST    = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_DELAY_LAST = c_TMR_W'(REP_DELAY - 1);
    localparam logic [c_TMR_W-1:0]  c_PER_LAST   = c_TMR_W'(REP_PERIOD - 1);
    localparam logic [c_CD_W-1:0]   c_CD_LOAD    = c_CD_W'(FIRE_COOLDOWN - 1);
    localparam logic [c_PRE_W-1:0]  c_PRE_LAST   = c_PRE_W'(CTRL_DIV - 1);
    localparam logic [c_GAME_W-1:0] c_GAME_LAST  = c_GAME_W'(GAME_DIV - 1);

    // Auto-repeat state encoding shared by every direction button
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [4:0]           r_sync1;
    logic [4:0]           r_sync2;
    logic [4:0]           w_level;       // current debounced level
    logic [4:0]           w_db_done;     // level toggles at the coming edge
    logic [4:0]           w_level_next;  // level as it will read after the edge
    logic [4:0]           w_rise;        // level goes 0 -> 1 at the coming edge
    logic [c_NUM_DIR-1:0] w_dir_pulse;
    logic                 r_fire;
    logic [c_CD_W-1:0]    r_cool;
    logic [c_PRE_W-1:0]   r_pre;
    logic [c_PRE_W-1:0]   w_pre_next;
    logic [c_GAME_W-1:0]  r_game;
    logic [c_GAME_W-1:0]  w_game_next;
    logic                 r_ctrl_tick;
    logic                 r_game_tick;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer on every raw button input
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-button debouncer: the level follows the synchronized input only
    // after DB_CYCLES consecutive differing samples. Any sample that agrees
    // with the current level restarts the count, so short glitches vanish.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 5; i++) begin : g_db
            logic [c_DB_W-1:0] r_cnt;
            logic              r_lvl;

            assign w_db_done[i]    = (r_sync2[i] != r_lvl) && (r_cnt == c_DB_LAST);
            assign w_level[i]      = r_lvl;
            assign w_level_next[i] = r_lvl ^ w_db_done[i];
            assign w_rise[i]       = w_db_done[i] & ~r_lvl;

            // Count differing samples; toggle the level on the last one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_sync2[i] == r_lvl) begin
                    r_cnt <= '0;
                end else if (w_db_done[i]) begin
                    r_lvl <= ~r_lvl;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Direction buttons: press strobe, then auto-repeat while held.
    // The FSM reacts to the level as it will read after this edge, so the
    // press strobe lines up with the first cycle the level reads 1 and a
    // release cancels any strobe due in that same cycle.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_NUM_DIR; i++) begin : g_dir
            rep_state_e         r_state;
            logic [c_TMR_W-1:0] r_tmr;
            logic               r_pls;

            assign w_dir_pulse[i] = r_pls;

            // Auto-repeat state machine with registered strobe output
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_IDLE;
                    r_tmr   <= '0;
                    r_pls   <= 1'b0;
                end else begin
                    r_pls <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            r_tmr <= '0;
                            if (w_rise[i]) begin
                                r_pls   <= 1'b1;
                                r_state <= ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (!w_level_next[i]) begin
                                r_state <= ST_IDLE;
                                r_tmr   <= '0;
                            end else if (r_tmr == c_DELAY_LAST) begin
                                // Suppress only if a strobe was just issued,
                                // which matters for a one-cycle delay setting
                                r_pls   <= ~r_pls;
                                r_state <= ST_REPEAT;
                                r_tmr   <= '0;
                            end else begin
                                r_tmr <= r_tmr + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (!w_level_next[i]) begin
                                r_state <= ST_IDLE;
                                r_tmr   <= '0;
                            end else if (r_tmr == c_PER_LAST) begin
                                r_pls <= ~r_pls;
                                r_tmr <= '0;
                            end else begin
                                r_tmr <= r_tmr + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_tmr   <= '0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Attack button: one strobe per press, presses during cooldown dropped.
    // A dropped press neither reloads nor pauses the cooldown.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fire <= 1'b0;
            r_cool <= '0;
        end else begin
            r_fire <= 1'b0;
            if (w_rise[c_ATT_BIT] && (r_cool == '0)) begin
                r_fire <= 1'b1;
                r_cool <= c_CD_LOAD;
            end else if (r_cool != '0) begin
                r_cool <= r_cool - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tick generation. Both strobes are registered by computing the counter
    // values one edge ahead, so each strobe is high exactly while its
    // counter sits on the last value.
    // ------------------------------------------------------------------------
    assign w_pre_next  = (r_pre == c_PRE_LAST) ? '0 : r_pre + 1'b1;
    assign w_game_next = !r_ctrl_tick          ? r_game :
                         (r_game == c_GAME_LAST) ? '0 : r_game + 1'b1;

    // Prescaler, game counter and their registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_game      <= '0;
            r_ctrl_tick <= 1'b0;
            r_game_tick <= 1'b0;
        end else begin
            r_pre       <= w_pre_next;
            r_game      <= w_game_next;
            r_ctrl_tick <= (w_pre_next == c_PRE_LAST);
            r_game_tick <= (w_pre_next == c_PRE_LAST) && (w_game_next == c_GAME_LAST);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign btn_level = w_level;
    assign btn_pulse = {r_fire, w_dir_pulse};
    assign ctrl_tick = r_ctrl_tick;
    assign game_tick = r_game_tick;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed and random stimulus for button_conditioner, compared
//            every cycle against a behavioural model built from edge-indexed
//            input history and elapsed-time arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int FC = 20;
    localparam int CD = 3;
    localparam int GD = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [4:0] btn_in = 5'b0;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic       ctrl_tick;
    logic       game_tick;

    always #5 clk = ~clk;

    button_conditioner #(
        .DB_CYCLES    (DB),
        .REP_DELAY    (RD),
        .REP_PERIOD   (RP),
        .FIRE_COOLDOWN(FC),
        .CTRL_DIV     (CD),
        .GAME_DIV     (GD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .ctrl_tick(ctrl_tick),
        .game_tick(game_tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: t = rising edges since reset release
    logic [4:0] in_at [0:8191];
    int         t;
    logic [4:0] m_lvl;
    logic [4:0] m_pls;
    int         rise_t [0:4];
    int         last_fire;
    bit         fired;

    // Value seen by the debouncer at edge k: input two edges earlier,
    // zero while the synchronizer still holds reset contents
    function automatic logic [4:0] sample_at(input int k);
        return (k >= 3) ? in_at[k-2] : 5'b0;
    endfunction

    task automatic model_reset();
        t         = 0;
        m_lvl     = '0;
        m_pls     = '0;
        fired     = 1'b0;
        last_fire = 0;
        for (int i = 0; i < 5; i++) rise_t[i] = 0;
    endtask

    task automatic model_edge(input logic [4:0] b);
        logic [4:0] prev;
        logic [4:0] s;
        bit         all_diff;
        int         d;
        t        = t + 1;
        in_at[t] = b;
        prev     = m_lvl;
        // Level flips when the last DB samples all disagree with it
        for (int i = 0; i < 5; i++) begin
            all_diff = 1'b1;
            for (int k = t - DB + 1; k <= t; k++) begin
                s = sample_at(k);
                if (s[i] == prev[i]) all_diff = 1'b0;
            end
            if (all_diff) m_lvl[i] = ~prev[i];
        end
        m_pls = '0;
        // Directions: strobe at press, at RD after press, then every RP
        for (int i = 0; i < 4; i++) begin
            if (m_lvl[i] && !prev[i]) begin
                m_pls[i]  = 1'b1;
                rise_t[i] = t;
            end else if (m_lvl[i] && prev[i]) begin
                d = t - rise_t[i];
                if (d == RD || (d > RD && ((d - RD) % RP) == 0)) m_pls[i] = 1'b1;
            end
        end
        // Attack: strobe only if FC or more edges since the last accepted one
        if (m_lvl[4] && !prev[4] && (!fired || (t - last_fire) >= FC)) begin
            m_pls[4]  = 1'b1;
            fired     = 1'b1;
            last_fire = t;
        end
    endtask

    task automatic check_all();
        logic exp_ctrl;
        logic exp_game;
        exp_ctrl = ((t % CD) == CD - 1);
        exp_game = ((t % (CD * GD)) == CD * GD - 1);
        checks++;
        assert (btn_level === m_lvl) else begin
            errors++;
            $error("FAIL level t=%0d observed=%b expected=%b", t, btn_level, m_lvl);
        end
        checks++;
        assert (btn_pulse === m_pls) else begin
            errors++;
            $error("FAIL pulse t=%0d observed=%b expected=%b", t, btn_pulse, m_pls);
        end
        checks++;
        assert (ctrl_tick === exp_ctrl) else begin
            errors++;
            $error("FAIL ctrl_tick t=%0d observed=%b expected=%b", t, ctrl_tick, exp_ctrl);
        end
        checks++;
        assert (game_tick === exp_game) else begin
            errors++;
            $error("FAIL game_tick t=%0d observed=%b expected=%b", t, game_tick, exp_game);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({btn_level, btn_pulse, ctrl_tick, game_tick} === 12'b0) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag,
                   {btn_level, btn_pulse, ctrl_tick, game_tick}, 12'b0);
        end
    endtask

    // Drive one input value, let one edge pass, then compare
    task automatic step(input logic [4:0] b);
        btn_in = b;
        @(posedge clk);
        #1;
        model_edge(b);
        check_all();
    endtask

    initial begin
        logic [4:0] rb;
        int         len;

        // Reset state
        rst_n  = 1'b0;
        btn_in = 5'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        model_reset();

        // Free run: tick cadence
        repeat (36) step(5'b00000);

        // Glitch shorter than the debounce window, then a clean press
        repeat (3)  step(5'b00001);
        repeat (8)  step(5'b00000);
        repeat (20) step(5'b00001);
        repeat (10) step(5'b00000);

        // Long hold with auto-repeat, then release
        repeat (40) step(5'b00010);
        repeat (10) step(5'b00000);

        // Attack: fire, early re-press dropped, late re-press accepted
        repeat (6)  step(5'b10000);
        repeat (6)  step(5'b00000);
        repeat (6)  step(5'b10000);
        repeat (8)  step(5'b00000);
        repeat (10) step(5'b10000);
        repeat (10) step(5'b00000);

        // All five simultaneously
        repeat (30) step(5'b11111);
        repeat (10) step(5'b00000);

        // Reset during repeat and cooldown, buttons held through release
        repeat (25) step(5'b10100);
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;
        model_reset();
        repeat (30) step(5'b10100);
        repeat (10) step(5'b00000);

        // Random segments of random length
        repeat (30) begin
            rb  = 5'($urandom);
            len = $urandom_range(1, 30);
            repeat (len) step(rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 1000000: consecutive stable samples needed to accept a button level change.
REQ-002 Parameter REP_DELAY, default 50000000: cycles from first movement pulse to first auto-repeat pulse.
REQ-003 Parameter REP_PERIOD, default 20000000: cycles between later auto-repeat pulses.
REQ-004 Parameter FIRE_COOLDOWN, default 150000000: cycles after a fire pulse during which att presses are discarded.
REQ-005 Parameter CTRL_DIV, default 10000000: clk cycles per ctrl_tick; GAME_DIV, default 15: ctrl_ticks per game_tick.
REQ-006 clk  input  1  single system clock; all state SHALL be on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn_in  input  5  raw asynchronous buttons; bit0 left0, bit1 right0, bit2 left1, bit3 right1, bit4 att; 1 = pressed.
REQ-009 btn_level  output  5  debounced button levels, same bit order.
REQ-010 btn_pulse  output  5  one-cycle press/repeat/fire strobes, same bit order.
REQ-011 ctrl_tick  output  1  one-cycle strobe every CTRL_DIV cycles; downstream control-update enable.
REQ-012 game_tick  output  1  one-cycle strobe every CTRL_DIV*GAME_DIV cycles; bullet/score update enable.

Function
REQ-013 Each btn_in bit SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Per bit: synced value differs from btn_level -> counter increments; synced equals btn_level -> counter clears to 0.
REQ-015 When the counter reaches DB_CYCLES-1 and the synced value still differs, btn_level SHALL toggle on the next edge and the counter SHALL clear; glitches shorter than DB_CYCLES SHALL never reach btn_level.
REQ-016 Bits 0-3 SHALL each run an FSM with states IDLE, DELAY, REPEAT and one timer.
REQ-017 IDLE: on btn_level rising, btn_pulse bit high in the same cycle btn_level first reads 1; go to DELAY, timer cleared.
REQ-018 DELAY: timer counts each cycle; at REP_DELAY-1 emit pulse, go to REPEAT, clear timer.
REQ-019 REPEAT: timer counts; at REP_PERIOD-1 emit pulse, clear timer, stay in REPEAT.
REQ-020 In DELAY or REPEAT, btn_level 0 SHALL force IDLE and clear the timer in the same cycle; no pulse on release.
REQ-021 Bit 4 (att) SHALL not auto-repeat; a btn_level rising edge emits a pulse only when the cooldown counter is 0, then loads it with FIRE_COOLDOWN-1.
REQ-022 Cooldown SHALL decrement to 0 and saturate; a rising edge while non-zero is dropped, not queued, and does not reload.
REQ-023 btn_pulse bits SHALL be registered and never high for 2 consecutive cycles.
REQ-024 Prescaler SHALL count 0..CTRL_DIV-1 and wrap; ctrl_tick is high in the cycle the count equals CTRL_DIV-1.
REQ-025 A second counter SHALL count ctrl_ticks 0..GAME_DIV-1; game_tick is high only in coincidence with the ctrl_tick that wraps it.
REQ-026 Bits SHALL be fully independent: simultaneous presses on any combination yield independent, concurrent pulses.
REQ-027 Latency from btn_in edge to btn_level change SHALL be exactly DB_CYCLES+2 cycles for a clean edge.

Reset
REQ-028 rst_n low SHALL immediately clear btn_level, btn_pulse, ctrl_tick, game_tick, synchronizers, all counters and cooldown, and force all FSMs to IDLE.
REQ-029 Reset asserted mid-operation (DELAY, REPEAT, cooldown) SHALL abort it; nothing resumes after release.
REQ-030 A button held through reset release SHALL be treated as a fresh press: one pulse DB_CYCLES+2 cycles after release.
REQ-031 Prescaler and game counter SHALL restart from 0 at reset release; first ctrl_tick occurs CTRL_DIV cycles after.

Verification (DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=5, FIRE_COOLDOWN=20, CTRL_DIV=3, GAME_DIV=4)
REQ-032 btn_in[0] 3-cycle glitch, then clean press -> no level change or pulse from glitch; btn_level[0] rises 6 cycles after clean edge, btn_pulse[0] high that cycle.
REQ-033 Hold btn_in[1] 40 cycles -> pulses at relative cycles 0, 10, 15, 20, 25, 30...; release -> pulses stop, FSM IDLE.
REQ-034 att pressed, released, re-pressed 12 cycles after fire -> no second pulse; re-press after 25 cycles -> pulse.
REQ-035 Free-run 36 cycles after reset -> ctrl_tick every 3rd cycle (12 ticks), game_tick every 12th cycle, always coincident with ctrl_tick.
REQ-036 rst_n pulsed low while bit2 in REPEAT and att cooldown active -> all outputs 0 at once; still-held bit2 pulses once 6 cycles after release, then follows REQ-033 timing.
REQ-037 All five buttons pressed simultaneously -> five pulses in the same cycle; bits 0-3 repeat in lockstep, bit 4 does not.
